canny: RTL and testbench
========================

# canny

Fully pipelined Sobel-gradient stage of the Canny edge-detection datapath. Each cycle it accepts one 3x3 window of 16-bit pixels and computes:
- horizontal and vertical gradient magnitudes with their signs;
- a combined edge strength.

It sits between the window/line-buffer front end and the edge-map writer. Throughput is one window per clock.

## Interface
Parameters:
- THRESHOLD, 16'd100 — edge-strength threshold used only when CANNY_THRESH_EN is defined.

Ports (imRC = row R, column C; row 1 top, column 1 left):
- clk  input  1  — single clock; all state updates on rising edge.
- reset  input  1  — asynchronous, active-high; clears all pipeline state.
- start  input  1  — window-valid qualifier; window sampled on rising edge when high.
- im11, im12, im13  input  16 each — top row, unsigned pixels.
- im21, im22, im23  input  16 each — middle row (im22 unused by Sobel).
- im31, im32, im33  input  16 each — bottom row.
- dx_out  output  16 — |Gx|, saturated.
- dx_out_sign  output  1 — 1 when Gx < 0.
- dy_out  output  16 — |Gy|, saturated.
- dy_out_sign  output  1 — 1 when Gy < 0.
- dxy  output  16 — edge strength (see Configuration).
- data_occur  output  1 — high for one cycle per valid result.

## Operation
- Gx = (im13 + 2·im23 + im33) − (im11 + 2·im21 + im31).
- Gy = (im31 + 2·im32 + im33) − (im11 + 2·im12 + im13).
- Arithmetic widths:
  - Weighted column/row sums are 18-bit unsigned (max 262140).
  - Differences are 19-bit signed.
  - Magnitudes are 18-bit unsigned.
- Output derivation:
  - dx_out = |Gx| saturated to 16'hFFFF; dx_out_sign = Gx[18].
  - dy_out and dy_out_sign are derived the same way from Gy.
  - Sign is 0 when the gradient is 0.
  - mag = |Gx| + |Gy| (19-bit, unsaturated operands), saturated to 16'hFFFF.
- Pipeline stages:
  - S1: register the four weighted sums plus valid.
  - S2: register Gx/Gy magnitudes and signs plus valid.
  - S3: register all outputs plus data_occur.
- Behaviour when start = 0:
  - A bubble propagates through the pipeline.
  - data_occur goes low in the corresponding cycle.
  - dx_out, dy_out, both signs and dxy hold their last values.
- Stalls: none; downstream must accept every result.

## Timing
- Reset values: all outputs 0, including dxy, data_occur and both signs. All stage-valid bits are also 0.
- Latency and alignment:
  - A window sampled at rising edge N (start = 1) appears on all outputs after edge N+2.
  - data_occur is high during the cycle following edge N+2.
  - All outputs update together from the same S3 register.
- Back-to-back: start held high for K cycles yields K consecutive data_occur cycles, in order, with no gaps.
- Reset mid-operation: every in-flight window is discarded. After reset deasserts, no data_occur occurs until 3 edges after the next sampled window.
- Inputs are not required to be stable when start = 0.

## Configuration
- Macro: CANNY_THRESH_EN.
- Defined: dxy is binarized.
  - dxy = 16'hFFFF when mag ≥ THRESHOLD (mag computed before saturation), else 16'h0000.
  - dx_out, dy_out and the signs are unaffected.
- Undefined: dxy = saturated mag. THRESHOLD is ignored.
- Latency and ports are identical in both builds.

## Test plan
- Flat window, all pixels 16'h0010, start = 1 at edge N:
  - dx_out = dy_out = dxy = 0, signs 0.
  - data_occur high only in the cycle after edge N+2.
- Vertical edge, columns 1 = 0 and column 3 = 100:
  - dx_out = 400 (16'h0190), dx_out_sign = 0, dy_out = 0, dxy = 400.
  - With CANNY_THRESH_EN: dxy = 16'hFFFF.
- Mirrored edges:
  - Column 1 = 100, column 3 = 0 → dx_out = 400, dx_out_sign = 1.
  - Row 1 = 0, row 3 = 50 → dy_out = 200, dy_out_sign = 0, dxy = 200.
  - Weak window with Gx = 40 → dxy = 40 without the macro, 0 with CANNY_THRESH_EN.
- Saturation: column 3 = 16'hFFFF, rest 0 → dx_out = 16'hFFFF, dxy = 16'hFFFF, dx_out_sign = 0.
- Streaming and reset:
  - Drive 4 different windows back-to-back, one idle cycle, then 2 more → 6 results in order; data_occur low exactly once between them.
  - Assert reset while 2 windows are in flight → outputs immediately 0; those results never appear.

Source files
------------

// File: rtl/canny.sv
// canny: fully pipelined Sobel gradient stage of the Canny edge datapath.
// Accepts one 3x3 window of 16-bit pixels per clock, produces |Gx|, |Gy|,
// their signs and a combined edge strength three edges after sampling.
// Optional build macro: CANNY_THRESH_EN binarizes dxy against THRESHOLD.
module canny #(
    parameter logic [15:0] THRESHOLD = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] im11,
    input  logic [15:0] im12,
    input  logic [15:0] im13,
    input  logic [15:0] im21,
    input  logic [15:0] im22,
    input  logic [15:0] im23,
    input  logic [15:0] im31,
    input  logic [15:0] im32,
    input  logic [15:0] im33,
    output logic [15:0] dx_out,
    output logic        dx_out_sign,
    output logic [15:0] dy_out,
    output logic        dy_out_sign,
    output logic [15:0] dxy,
    output logic        data_occur
);

    // Centre pixel plays no part in Sobel; THRESHOLD is idle in the default build.
    logic w_unused;
    assign w_unused = ^{im22, THRESHOLD};

    // Stage 1 weighted sums: right/left columns for Gx, bottom/top rows for Gy.
    logic [17:0] w_sx_pos, w_sx_neg, w_sy_pos, w_sy_neg;
    assign w_sx_pos = {2'b00, im13} + {1'b0, im23, 1'b0} + {2'b00, im33};
    assign w_sx_neg = {2'b00, im11} + {1'b0, im21, 1'b0} + {2'b00, im31};
    assign w_sy_pos = {2'b00, im31} + {1'b0, im32, 1'b0} + {2'b00, im33};
    assign w_sy_neg = {2'b00, im11} + {1'b0, im12, 1'b0} + {2'b00, im13};

    logic [17:0] r_sx_pos, r_sx_neg, r_sy_pos, r_sy_neg;
    logic        r_v1;

    // S1: capture weighted sums for valid windows; bubbles only clear the valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sx_pos <= '0;
            r_sx_neg <= '0;
            r_sy_pos <= '0;
            r_sy_neg <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= start;
            if (start) begin
                r_sx_pos <= w_sx_pos;
                r_sx_neg <= w_sx_neg;
                r_sy_pos <= w_sy_pos;
                r_sy_neg <= w_sy_neg;
            end
        end
    end

    // Stage 2 signed differences (19-bit two's complement) and magnitudes.
    logic [18:0] w_gx, w_gy, w_gx_neg, w_gy_neg;
    logic [17:0] w_gx_mag, w_gy_mag;
    assign w_gx     = {1'b0, r_sx_pos} - {1'b0, r_sx_neg};
    assign w_gy     = {1'b0, r_sy_pos} - {1'b0, r_sy_neg};
    assign w_gx_neg = 19'd0 - w_gx;
    assign w_gy_neg = 19'd0 - w_gy;
    assign w_gx_mag = w_gx[18] ? w_gx_neg[17:0] : w_gx[17:0];
    assign w_gy_mag = w_gy[18] ? w_gy_neg[17:0] : w_gy[17:0];

    logic [17:0] r_gx_mag, r_gy_mag;
    logic        r_gx_sign, r_gy_sign;
    logic        r_v2;

    // S2: register magnitudes and signs of both gradients.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gx_mag  <= '0;
            r_gy_mag  <= '0;
            r_gx_sign <= 1'b0;
            r_gy_sign <= 1'b0;
            r_v2      <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_gx_mag  <= w_gx_mag;
                r_gy_mag  <= w_gy_mag;
                r_gx_sign <= w_gx[18];
                r_gy_sign <= w_gy[18];
            end
        end
    end

    // Stage 3 saturation and edge strength from the unsaturated magnitudes.
    logic [15:0] w_dx_sat, w_dy_sat, w_dxy;
    logic [18:0] w_mag;
    assign w_dx_sat = (|r_gx_mag[17:16]) ? 16'hFFFF : r_gx_mag[15:0];
    assign w_dy_sat = (|r_gy_mag[17:16]) ? 16'hFFFF : r_gy_mag[15:0];
    assign w_mag    = {1'b0, r_gx_mag} + {1'b0, r_gy_mag};

`ifdef CANNY_THRESH_EN
    assign w_dxy = (w_mag >= {3'b000, THRESHOLD}) ? 16'hFFFF : 16'h0000;
`else
    assign w_dxy = (|w_mag[18:16]) ? 16'hFFFF : w_mag[15:0];
`endif

    // S3: outputs load together on a valid result and hold through bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_out      <= '0;
            dx_out_sign <= 1'b0;
            dy_out      <= '0;
            dy_out_sign <= 1'b0;
            dxy         <= '0;
            data_occur  <= 1'b0;
        end else begin
            data_occur <= r_v2;
            if (r_v2) begin
                dx_out      <= w_dx_sat;
                dx_out_sign <= r_gx_sign;
                dy_out      <= w_dy_sat;
                dy_out_sign <= r_gy_sign;
                dxy         <= w_dxy;
            end
        end
    end

endmodule

// File: tb/tb_canny.sv
// tb_canny: scoreboard bench for the Sobel gradient stage.
module tb_canny;

    localparam logic [15:0] THR = 16'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] im11 = '0, im12 = '0, im13 = '0;
    logic [15:0] im21 = '0, im22 = '0, im23 = '0;
    logic [15:0] im31 = '0, im32 = '0, im33 = '0;
    logic [15:0] dx_out, dy_out, dxy;
    logic        dx_out_sign, dy_out_sign, data_occur;

    canny #(.THRESHOLD(THR)) dut (
        .clk(clk), .reset(reset), .start(start),
        .im11(im11), .im12(im12), .im13(im13),
        .im21(im21), .im22(im22), .im23(im23),
        .im31(im31), .im32(im32), .im33(im33),
        .dx_out(dx_out), .dx_out_sign(dx_out_sign),
        .dy_out(dy_out), .dy_out_sign(dy_out_sign),
        .dxy(dxy), .data_occur(data_occur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dx;
        logic        sx;
        logic [15:0] dy;
        logic        sy;
        logic [15:0] dxy;
    } exp_t;

    exp_t   sb[$];
    exp_t   last;
    logic [2:0] hist = 3'b000;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int p11, p12, p13, p21, p23, p31, p32, p33);
        exp_t e;
        int gx, gy, ax, ay, mag;
        gx  = (p13 + 2*p23 + p33) - (p11 + 2*p21 + p31);
        gy  = (p31 + 2*p32 + p33) - (p11 + 2*p12 + p13);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        e.dx = (ax > 65535) ? 16'hFFFF : 16'(ax);
        e.dy = (ay > 65535) ? 16'hFFFF : 16'(ay);
        e.sx = (gx < 0);
        e.sy = (gy < 0);
`ifdef CANNY_THRESH_EN
        e.dxy = (mag >= int'(THR)) ? 16'hFFFF : 16'h0000;
`else
        e.dxy = (mag > 65535) ? 16'hFFFF : 16'(mag);
`endif
        return e;
    endfunction

    // Push the expected result whenever a window is sampled.
    always @(posedge clk) begin
        if (!reset) begin
            hist = {hist[1:0], start};
            if (start)
                sb.push_back(model(int'(im11), int'(im12), int'(im13), int'(im21),
                                   int'(im23), int'(im31), int'(im32), int'(im33)));
        end
    end

    // Compare outputs mid-cycle: pop on data_occur, otherwise expect held values.
    always @(negedge clk) begin
        if (!reset) begin
            check("data_occur", {31'd0, data_occur}, {31'd0, hist[2]});
            if (data_occur) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    last = sb.pop_front();
                end
            end
            check("dx_out", {16'd0, dx_out}, {16'd0, last.dx});
            check("dx_sign", {31'd0, dx_out_sign}, {31'd0, last.sx});
            check("dy_out", {16'd0, dy_out}, {16'd0, last.dy});
            check("dy_sign", {31'd0, dy_out_sign}, {31'd0, last.sy});
            check("dxy", {16'd0, dxy}, {16'd0, last.dxy});
        end
    end

    task automatic drive(input logic [15:0] a11, a12, a13, a21, a22, a23, a31, a32, a33);
        start = 1'b1;
        im11 = a11; im12 = a12; im13 = a13;
        im21 = a21; im22 = a22; im23 = a23;
        im31 = a31; im32 = a32; im33 = a33;
        @(negedge clk);
    endtask

    task automatic drive_rand();
        drive(16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            im11 = 16'($urandom); im13 = 16'($urandom); im32 = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dx"}, {16'd0, dx_out}, 32'd0);
        check({tag, "_dy"}, {16'd0, dy_out}, 32'd0);
        check({tag, "_dxy"}, {16'd0, dxy}, 32'd0);
        check({tag, "_sgn"}, {30'd0, dx_out_sign, dy_out_sign}, 32'd0);
        check({tag, "_occur"}, {31'd0, data_occur}, 32'd0);
    endtask

    initial begin
        last = '{dx: 16'd0, sx: 1'b0, dy: 16'd0, sy: 1'b0, dxy: 16'd0};
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        drive(16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10);
        idle(4);
        drive(0, 50, 100, 0, 50, 100, 0, 50, 100);
        idle(3);
        drive(100, 50, 0, 100, 50, 0, 100, 50, 0);
        drive(0, 0, 0, 25, 25, 25, 50, 50, 50);
        drive(0, 0, 10, 0, 0, 10, 0, 0, 10);
        drive(0, 0, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 16'hFFFF);
        drive(16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        idle(4);

        for (int i = 0; i < 4; i++) drive_rand();
        idle(1);
        for (int i = 0; i < 2; i++) drive_rand();
        idle(4);

        drive(0, 0, 200, 0, 0, 200, 0, 0, 200);
        drive_rand();
        drive_rand();
        start = 1'b0;
        #2;
        reset = 1'b1;
        sb.delete();
        hist = 3'b000;
        last = '{dx: 16'd0, sx: 1'b0, dy: 16'd0, sy: 1'b0, dxy: 16'd0};
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand();
            else idle(1);
        end
        idle(6);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
